i2c_reg_seq: RTL and testbench
==============================

Name: i2c_reg_seq

Overview:
- Register-access sequencer that sits directly upstream of the I2C byte master and drives its command, data and write-strobe inputs.
- Turns a single request ("write reg R of device A with D" or "read reg R of device A") into the required master command sequence.
- Watches master status after each byte and returns one response with read data and an error code.
- Handles NACK (recovery STOP) and lost arbitration (backoff and retry).

Parameters:
- ALO_RETRIES, 3: retry attempts after arbitration lost before reporting failure.
- BACKOFF_CYC, 256: clk cycles waited before each retry; counter width $clog2(BACKOFF_CYC+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle; request accepted when req_valid&&req_ready.
- req_rnw  in  1  1=read, 0=write.
- req_addr  in  7  7-bit device address.
- req_reg  in  8  register index.
- req_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse, request finished.
- rsp_err  out  2  0=OK, 1=NACK, 2=arbitration lost, 3=protocol error.
- rsp_rdata  out  8  read data (valid with rsp_valid when rnw and rsp_err==0).
- m_cmd  out  5  master command: bit0 STRT, bit1 STOP, bit2 READ, bit3 WRTE, bit4 NACK.
- m_dat  out  8  master write data.
- m_ws  out  1  master command strobe.
- m_stat  in  4  master status: bit0 BSY, bit1 ERR, bit2 ALO, bit3 ACK.
- m_dat_in  in  8  master read data.

Behaviour:
- Reset values: req_ready=0 until state reaches IDLE (first clk after rst release), rsp_valid=0, rsp_err=0, rsp_rdata=0, m_cmd=0, m_dat=0, m_ws=0. State=IDLE, step=0, retry count=0.
- Accept: in IDLE with req_valid, latch all req_* fields and set step=0. req_ready drops the next cycle. The caller may change req_* after the accept.
- Write step table:
  - step 0: cmd=STRT|WRTE, dat={addr,0}
  - step 1: cmd=WRTE, dat=reg
  - step 2: cmd=WRTE|STOP, dat=wdata (last step)
- Read step table:
  - steps 0 and 1: as for write.
  - step 2: cmd=STRT|WRTE, dat={addr,1} (repeated start)
  - step 3: cmd=READ|NACK|STOP, dat=8'hff (last step)
- States: IDLE, ISSUE, SETTLE, WAIT, CHECK, RSTOP, RSTOP_W, BACKOFF, RESP.
- ISSUE:
  - m_cmd/m_dat are registered from the step table.
  - m_ws=1 for exactly one cycle, only in a cycle where m_stat[BSY]==0.
  - m_cmd/m_dat are held stable while m_ws=1.
  - Next state SETTLE.
- SETTLE: one cycle, m_ws=0; covers the master's registered status update. Next state WAIT.
- WAIT: stay while m_stat[BSY]==1, then go to CHECK.
- CHECK priority (highest first):
  - ALO=1: if retry count < ALO_RETRIES, increment it, load the backoff counter, go to BACKOFF, then to ISSUE at step 0. Otherwise rsp_err=2 and go to RESP. No STOP is issued; the master has already released the bus.
  - ERR=1 (ALO=0): rsp_err=3, then RSTOP.
  - Non-last step with ACK==0: rsp_err=1, then RSTOP.
  - Last write step with ACK==0: rsp_err=1, then RESP (the STOP is already included in the command).
  - Last read step: no ACK check; rsp_rdata<=m_dat_in, rsp_err=0, then RESP.
  - Otherwise: step+1, then ISSUE.
- RSTOP: issue cmd=STOP (all other bits 0) using the ISSUE rules, then wait BSY low via SETTLE/WAIT. Its status result is ignored. Then RESP.
- RESP:
  - rsp_valid=1 for one cycle.
  - rsp_err/rsp_rdata hold until the next RESP.
  - rsp_rdata is unchanged on any error.
  - Clear retry count, go to IDLE.
- The master is BSY for its init time after reset; ISSUE naturally waits on it.
- Reset mid-operation: all state is abandoned immediately and outputs return to reset values. No response is produced for the in-flight request.
- req_valid outside IDLE is ignored.

Test Plan:
- Write addr 0x50, reg 0x12, data 0xA5 with an ACKing slave model -> bus shows S,0xA0,0x12,0xA5,P; exactly 3 m_ws pulses; rsp_valid once, rsp_err=0.
- Read addr 0x50, reg 0x12, slave returns 0x3C -> bus shows S,0xA0,0x12,Sr,0xA1,0x3C+NACK,P; 4 m_ws pulses; rsp_rdata=0x3C, rsp_err=0.
- Read addr 0x51, no slave (address NACK) -> one extra STOP-only command; rsp_err=1; rsp_rdata keeps its previous value.
- Write with slave NACKing the data byte -> no extra STOP command; rsp_err=1 after the master STOP completes.
- Second master forces SDA low during address on the first 2 attempts -> 2 backoffs of BACKOFF_CYC cycles each, third attempt succeeds with rsp_err=0. Forcing on all 4 attempts -> rsp_err=2 after exactly 3 retries.
- Assert rst while in WAIT at step 1 -> outputs take reset values within the same cycle; no rsp_valid; the next request completes normally.

Source files
------------

// File: rtl/i2c_reg_seq_if.sv
// Request/response and byte-master signals of the register sequencer.
// The slave modport is the sequencer; master is the requester plus byte master.
interface i2c_reg_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rnw;
    logic [6:0] req_addr;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [1:0] rsp_err;
    logic [7:0] rsp_rdata;
    logic [4:0] m_cmd;
    logic [7:0] m_dat;
    logic       m_ws;
    logic [3:0] m_stat;
    logic [7:0] m_dat_in;

    modport slave (
        input  req_valid, req_rnw, req_addr, req_reg, req_wdata, m_stat, m_dat_in,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, m_cmd, m_dat, m_ws
    );

    modport master (
        output req_valid, req_rnw, req_addr, req_reg, req_wdata, m_stat, m_dat_in,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, m_cmd, m_dat, m_ws
    );
endinterface

// File: rtl/i2c_reg_seq.sv
// I2C register-access sequencer: expands one register read/write request into
// byte-master commands, handles NACK (recovery STOP) and arbitration-loss retry.
module i2c_reg_seq #(
    parameter int ALO_RETRIES = 3,
    parameter int BACKOFF_CYC = 256
) (
    input  logic         clk,
    input  logic         rst,
    i2c_reg_seq_if.slave bus
);
    localparam int RW = (ALO_RETRIES < 1) ? 1 : $clog2(ALO_RETRIES + 1);
    localparam int BW = (BACKOFF_CYC < 1) ? 1 : $clog2(BACKOFF_CYC + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(ALO_RETRIES);
    localparam logic [BW-1:0] BO_LOAD   = BW'(BACKOFF_CYC);

    localparam logic [4:0] C_STRT = 5'b00001;
    localparam logic [4:0] C_STOP = 5'b00010;
    localparam logic [4:0] C_READ = 5'b00100;
    localparam logic [4:0] C_WRTE = 5'b01000;
    localparam logic [4:0] C_NACK = 5'b10000;

    typedef enum logic [3:0] {
        IDLE, ISSUE, SETTLE, WAIT, CHECK, RSTOP, RSTOP_W, BACKOFF, RESP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [BW-1:0] bo_q, bo_d;
    logic          rnw_q, rnw_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    rreg_q, rreg_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          stop_q, stop_d;
    logic [1:0]    err_q, err_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [1:0]    rsp_err_q, rsp_err_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic [4:0]    m_cmd_q, m_cmd_d;
    logic [7:0]    m_dat_q, m_dat_d;
    logic          m_ws_q, m_ws_d;

    logic [4:0] tbl_cmd;
    logic [7:0] tbl_dat;
    logic       last;
    logic       bsy, st_err, st_alo, st_ack;

    assign bsy    = bus.m_stat[0];
    assign st_err = bus.m_stat[1];
    assign st_alo = bus.m_stat[2];
    assign st_ack = bus.m_stat[3];

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.m_cmd     = m_cmd_q;
    assign bus.m_dat     = m_dat_q;
    assign bus.m_ws      = m_ws_q;

    // Step table; reads differ from writes only from step 2 on (repeated start).
    always_comb begin
        tbl_cmd = C_WRTE;
        tbl_dat = rreg_q;
        case (step_q)
            2'd0: begin tbl_cmd = C_STRT | C_WRTE; tbl_dat = {addr_q, 1'b0}; end
            2'd1: begin tbl_cmd = C_WRTE;          tbl_dat = rreg_q;         end
            2'd2: begin
                if (rnw_q) begin tbl_cmd = C_STRT | C_WRTE; tbl_dat = {addr_q, 1'b1}; end
                else       begin tbl_cmd = C_WRTE | C_STOP; tbl_dat = wdata_q;        end
            end
            default: begin tbl_cmd = C_READ | C_NACK | C_STOP; tbl_dat = 8'hff; end
        endcase
        last = rnw_q ? (step_q == 2'd3) : (step_q == 2'd2);
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        retry_d     = retry_q;
        bo_d        = bo_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        rreg_d      = rreg_q;
        wdata_d     = wdata_q;
        stop_d      = stop_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        m_cmd_d     = m_cmd_q;
        m_dat_d     = m_dat_q;
        m_ws_d      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    rnw_d       = bus.req_rnw;
                    addr_d      = bus.req_addr;
                    rreg_d      = bus.req_reg;
                    wdata_d     = bus.req_wdata;
                    step_d      = 2'd0;
                    err_d       = 2'd0;
                    req_ready_d = 1'b0;
                    state_d     = ISSUE;
                end
            end
            // Strobe is raised only after seeing the master idle, then dropped.
            ISSUE, RSTOP: begin
                m_cmd_d = (state_q == RSTOP) ? C_STOP : tbl_cmd;
                m_dat_d = (state_q == RSTOP) ? 8'h00  : tbl_dat;
                m_ws_d  = !m_ws_q && !bsy;
                if (m_ws_q) begin
                    stop_d  = (state_q == RSTOP);
                    state_d = SETTLE;
                end
            end
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (!bsy) state_d = stop_q ? RSTOP_W : CHECK;
            end
            CHECK: begin
                if (st_alo) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        bo_d    = BO_LOAD;
                        state_d = BACKOFF;
                    end else begin
                        err_d   = 2'd2;
                        state_d = RESP;
                    end
                end else if (st_err) begin
                    err_d   = 2'd3;
                    state_d = RSTOP;
                end else if (!last && !st_ack) begin
                    err_d   = 2'd1;
                    state_d = RSTOP;
                end else if (last && !rnw_q) begin
                    // STOP already rode along with the final write byte.
                    err_d   = st_ack ? 2'd0 : 2'd1;
                    state_d = RESP;
                end else if (last) begin
                    rdata_d = bus.m_dat_in;
                    err_d   = 2'd0;
                    state_d = RESP;
                end else begin
                    step_d  = step_q + 2'd1;
                    state_d = ISSUE;
                end
            end
            RSTOP_W: begin
                stop_d  = 1'b0;
                state_d = RESP;
            end
            BACKOFF: begin
                if (bo_q <= BW'(1)) begin
                    step_d  = 2'd0;
                    state_d = ISSUE;
                end else begin
                    bo_d = bo_q - BW'(1);
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                if (rnw_q && err_q == 2'd0) rsp_rdata_d = rdata_q;
                retry_d     = '0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            retry_q     <= '0;
            bo_q        <= '0;
            rnw_q       <= 1'b0;
            addr_q      <= 7'd0;
            rreg_q      <= 8'd0;
            wdata_q     <= 8'd0;
            stop_q      <= 1'b0;
            err_q       <= 2'd0;
            rdata_q     <= 8'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 2'd0;
            rsp_rdata_q <= 8'd0;
            m_cmd_q     <= 5'd0;
            m_dat_q     <= 8'd0;
            m_ws_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            retry_q     <= retry_d;
            bo_q        <= bo_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            rreg_q      <= rreg_d;
            wdata_q     <= wdata_d;
            stop_q      <= stop_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            m_cmd_q     <= m_cmd_d;
            m_dat_q     <= m_dat_d;
            m_ws_q      <= m_ws_d;
        end
    end
endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq with a small byte-master model that logs
// every strobed command and answers with configurable ACK/ERR/ALO status.
module tb_i2c_reg_seq;
    localparam int BO  = 256;
    localparam int GAP = 7;   // strobe-to-strobe spacing with a 3-cycle busy master

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_reg_seq_if bus ();
    i2c_reg_seq #(.ALO_RETRIES(3), .BACKOFF_CYC(BO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Master model state and per-request scenario knobs.
    int         base_cmd, nack_idx, err_idx, alo_n;
    logic [7:0] rd_byte;
    int         n_cmd = 0, n_rsp = 0, cyc = 0, busy_cnt, rel;
    logic [3:0] stat_q;
    logic [7:0] din_q;
    logic [4:0] log_cmd [0:127];
    logic [7:0] log_dat [0:127];
    int         log_cyc [0:127];

    assign rel          = n_cmd - base_cmd;
    assign bus.m_stat   = stat_q;
    assign bus.m_dat_in = din_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rsp_valid) n_rsp <= n_rsp + 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 5;
            stat_q   <= 4'b0001;
            din_q    <= 8'h00;
        end else if (bus.m_ws) begin
            log_cmd[n_cmd & 127] <= bus.m_cmd;
            log_dat[n_cmd & 127] <= bus.m_dat;
            log_cyc[n_cmd & 127] <= cyc;
            n_cmd    <= n_cmd + 1;
            busy_cnt <= 3;
            stat_q   <= {(rel != nack_idx) && (rel != err_idx) && (rel >= alo_n),
                         rel < alo_n, rel == err_idx, 1'b1};
            din_q    <= bus.m_cmd[2] ? rd_byte : 8'h00;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) stat_q[0] <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic [4:0] c, input logic [7:0] d);
        check({tag, "_cmd"}, 32'(log_cmd[idx & 127]), 32'(c));
        check({tag, "_dat"}, 32'(log_dat[idx & 127]), 32'(d));
    endtask

    task automatic run_req(input logic rnw, input logic [6:0] a, input logic [7:0] r, input logic [7:0] wd,
                           output int b, output logic [1:0] err, output logic [7:0] rd,
                           output int ncmd, output int nrsp);
        int  r0;
        bit  got;
        b = n_cmd; base_cmd = n_cmd; r0 = n_rsp; got = 0; err = 2'd0; rd = 8'h00;
        for (int i = 0; i < 100 && !bus.req_ready; i++) @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_rnw = rnw; bus.req_addr = a;
        bus.req_reg = r; bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_rnw = ~rnw; bus.req_addr = ~a;
        bus.req_reg = ~r; bus.req_wdata = ~wd;
        for (int i = 0; i < 3000; i++) begin
            if (bus.rsp_valid) begin
                got = 1; err = bus.rsp_err; rd = bus.rsp_rdata;
                break;
            end
            @(negedge clk);
        end
        check("rsp_seen", 32'(got), 32'd1);
        repeat (10) @(negedge clk);
        ncmd = n_cmd - b;
        nrsp = n_rsp - r0;
    endtask

    int         b, ncmd, nrsp, r0;
    logic [1:0] err;
    logic [7:0] rd;

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_rnw = 1'b0; bus.req_addr = 7'd0;
        bus.req_reg = 8'd0; bus.req_wdata = 8'd0;
        base_cmd = 0; nack_idx = -1; err_idx = -1; alo_n = 0; rd_byte = 8'h00;
        #2;
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_err", 32'(bus.rsp_err), 0);
        check("rst_rdata", 32'(bus.rsp_rdata), 0);
        check("rst_m_cmd", 32'(bus.m_cmd), 0);
        check("rst_m_dat", 32'(bus.m_dat), 0);
        check("rst_m_ws", 32'(bus.m_ws), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("ready_before_clk", 32'(bus.req_ready), 0);
        @(negedge clk);
        check("ready_after_clk", 32'(bus.req_ready), 1);

        // Plain write: S,A0,12,A5,P
        run_req(1'b0, 7'h50, 8'h12, 8'hA5, b, err, rd, ncmd, nrsp);
        check("wr_ncmd", ncmd, 3);
        check_log("wr0", b,     5'h09, 8'hA0);
        check_log("wr1", b + 1, 5'h08, 8'h12);
        check_log("wr2", b + 2, 5'h0A, 8'hA5);
        check("wr_gap", log_cyc[(b + 1) & 127] - log_cyc[b & 127], GAP);
        check("wr_nrsp", nrsp, 1);
        check("wr_err", 32'(err), 0);

        // Read with repeated start, slave returns 3C
        rd_byte = 8'h3C;
        run_req(1'b1, 7'h50, 8'h12, 8'h00, b, err, rd, ncmd, nrsp);
        check("rd_ncmd", ncmd, 4);
        check_log("rd0", b,     5'h09, 8'hA0);
        check_log("rd1", b + 1, 5'h08, 8'h12);
        check_log("rd2", b + 2, 5'h09, 8'hA1);
        check_log("rd3", b + 3, 5'h16, 8'hFF);
        check("rd_nrsp", nrsp, 1);
        check("rd_err", 32'(err), 0);
        check("rd_data", 32'(rd), 32'h3C);

        // Read of an absent device: address NACK, recovery STOP, data kept
        nack_idx = 0; rd_byte = 8'h77;
        run_req(1'b1, 7'h51, 8'h12, 8'h00, b, err, rd, ncmd, nrsp);
        nack_idx = -1;
        check("nack_ncmd", ncmd, 2);
        check_log("nack0", b, 5'h09, 8'hA2);
        check("nack_stop", 32'(log_cmd[(b + 1) & 127]), 32'h02);
        check("nack_err", 32'(err), 1);
        check("nack_rdata", 32'(rd), 32'h3C);

        // Data byte NACK on write: STOP already part of last command
        nack_idx = 2;
        run_req(1'b0, 7'h50, 8'h34, 8'h5A, b, err, rd, ncmd, nrsp);
        nack_idx = -1;
        check("dnack_ncmd", ncmd, 3);
        check_log("dnack2", b + 2, 5'h0A, 8'h5A);
        check("dnack_err", 32'(err), 1);
        check("dnack_nrsp", nrsp, 1);

        // Master ERR on register byte: protocol error plus recovery STOP
        err_idx = 1;
        run_req(1'b0, 7'h50, 8'h34, 8'h5A, b, err, rd, ncmd, nrsp);
        err_idx = -1;
        check("perr_ncmd", ncmd, 3);
        check("perr_stop", 32'(log_cmd[(b + 2) & 127]), 32'h02);
        check("perr_err", 32'(err), 3);

        // Arbitration lost twice, then success
        alo_n = 2;
        run_req(1'b0, 7'h50, 8'h12, 8'hA5, b, err, rd, ncmd, nrsp);
        alo_n = 0;
        check("alo2_ncmd", ncmd, 5);
        check("alo2_gap1", log_cyc[(b + 1) & 127] - log_cyc[b & 127], GAP + BO);
        check("alo2_gap2", log_cyc[(b + 2) & 127] - log_cyc[(b + 1) & 127], GAP + BO);
        check("alo2_gap3", log_cyc[(b + 3) & 127] - log_cyc[(b + 2) & 127], GAP);
        check_log("alo2_a1", b + 1, 5'h09, 8'hA0);
        check_log("alo2_d", b + 4, 5'h0A, 8'hA5);
        check("alo2_err", 32'(err), 0);

        // Arbitration lost on every attempt: three retries then give up
        alo_n = 4;
        run_req(1'b0, 7'h50, 8'h12, 8'hA5, b, err, rd, ncmd, nrsp);
        alo_n = 0;
        check("alo4_ncmd", ncmd, 4);
        check_log("alo4_last", b + 3, 5'h09, 8'hA0);
        check("alo4_gap3", log_cyc[(b + 3) & 127] - log_cyc[(b + 2) & 127], GAP + BO);
        check("alo4_err", 32'(err), 2);
        check("alo4_rdata", 32'(rd), 32'h3C);
        check("alo4_nrsp", nrsp, 1);

        // Reset while waiting on step 1 of a write
        b = n_cmd; base_cmd = n_cmd; r0 = n_rsp;
        bus.req_valid = 1'b1; bus.req_rnw = 1'b0; bus.req_addr = 7'h50;
        bus.req_reg = 8'h12; bus.req_wdata = 8'hA5;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 200 && (n_cmd - b) < 2; i++) @(negedge clk);
        @(negedge clk);
        check("mid_cmd", 32'(bus.m_cmd), 32'h08);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd", 32'(bus.m_cmd), 0);
        check("mid_rst_dat", 32'(bus.m_dat), 0);
        check("mid_rst_ready", 32'(bus.req_ready), 0);
        check("mid_rst_rdata", 32'(bus.rsp_rdata), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_no_rsp", n_rsp - r0, 0);

        run_req(1'b0, 7'h50, 8'h12, 8'hA5, b, err, rd, ncmd, nrsp);
        check("post_ncmd", ncmd, 3);
        check_log("post2", b + 2, 5'h0A, 8'hA5);
        check("post_err", 32'(err), 0);
        check("post_nrsp", nrsp, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
